// File: rtl/rtc_pkg.sv
// rtc_pkg: shared widths, set_field codes, time record type and calendar
// helper functions for the rtc_calendar slice.
package rtc_pkg;

  localparam int unsigned W_YEAR  = 16;
  localparam int unsigned W_MONTH = 4;
  localparam int unsigned W_DAY   = 5;
  localparam int unsigned W_HOUR  = 5;
  localparam int unsigned W_MIN   = 6;
  localparam int unsigned W_SEC   = 6;
  localparam int unsigned W_WEEK  = 3;
  localparam int unsigned W_FIELD = 3;
  localparam int unsigned W_VALUE = 16;

  localparam logic [W_FIELD-1:0] FIELD_SEC   = 3'd0;
  localparam logic [W_FIELD-1:0] FIELD_MIN   = 3'd1;
  localparam logic [W_FIELD-1:0] FIELD_HOUR  = 3'd2;
  localparam logic [W_FIELD-1:0] FIELD_DAY   = 3'd3;
  localparam logic [W_FIELD-1:0] FIELD_MONTH = 3'd4;
  localparam logic [W_FIELD-1:0] FIELD_YEAR  = 3'd5;
  localparam logic [W_FIELD-1:0] FIELD_AHOUR = 3'd6;
  localparam logic [W_FIELD-1:0] FIELD_AMIN  = 3'd7;

  typedef struct packed {
    logic [W_YEAR-1:0]  year;
    logic [W_MONTH-1:0] month;
    logic [W_DAY-1:0]   day;
    logic [W_HOUR-1:0]  hour;
    logic [W_MIN-1:0]   minute;
    logic [W_SEC-1:0]   second;
    logic [W_WEEK-1:0]  week;
  } rtc_time_t;

  function automatic logic is_leap(input logic [W_YEAR-1:0] year);
    return ((year % 16'd4) == 16'd0) &&
           (((year % 16'd100) != 16'd0) || ((year % 16'd400) == 16'd0));
  endfunction

  function automatic logic [W_DAY-1:0] days_in_month(input logic [W_MONTH-1:0] month,
                                                     input logic [W_YEAR-1:0]  year);
    logic [W_DAY-1:0] len;
    case (month)
      4'd2:                     len = is_leap(year) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  len = 5'd30;
      default:                  len = 5'd31;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/rtc_calendar_if.sv
// rtc_calendar_if: field-write handshake between a host (master) and the
// calendar (slave).
interface rtc_calendar_if;
  import rtc_pkg::*;

  logic               set_valid;
  logic               set_ready;
  logic [W_FIELD-1:0] set_field;
  logic [W_VALUE-1:0] set_value;
  logic               set_err;

  modport master (
    output set_valid, set_field, set_value,
    input  set_ready, set_err
  );

  modport slave (
    input  set_valid, set_field, set_value,
    output set_ready, set_err
  );

endinterface

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides clk by CLK_HZ; tick is high for the single cycle in
// which the count sits at CLK_HZ-1 while enabled.
module rtc_prescaler #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = en && (count_q == LAST);

  // next count: clear wins, wrap on tick, otherwise advance while enabled
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rtc_calendar.sv
// rtc_calendar: binary real-time clock/calendar with field-write port.
// Optional alarm compare enabled by defining RTC_CALENDAR_ALARM_EN.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned YEAR_BASE = 2000,
  parameter int unsigned YEAR_MAX  = 2099,
  parameter int unsigned WEEK_INIT = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  rtc_calendar_if.slave      set_if,
  output logic [W_YEAR-1:0]  year,
  output logic [W_MONTH-1:0] month,
  output logic [W_DAY-1:0]   day,
  output logic [W_HOUR-1:0]  hour,
  output logic [W_MIN-1:0]   minute,
  output logic [W_SEC-1:0]   second,
  output logic [W_WEEK-1:0]  week,
  output logic               sec_pulse,
  output logic               alarm_hit
);

  localparam logic [W_YEAR-1:0] YEAR_BASE_V = W_YEAR'(YEAR_BASE);
  localparam logic [W_YEAR-1:0] YEAR_MAX_V  = W_YEAR'(YEAR_MAX);
  localparam rtc_time_t RESET_TIME = '{
    year:   YEAR_BASE_V,
    month:  4'd1,
    day:    5'd1,
    hour:   '0,
    minute: '0,
    second: '0,
    week:   W_WEEK'(WEEK_INIT)
  };

  logic               tick;
  logic               clr;
  logic               accept;
  logic [W_VALUE-1:0] val;
  logic [W_DAY-1:0]   cur_dim;
  logic [W_DAY-1:0]   new_dim;

  rtc_time_t time_q, time_d;
  logic      sec_pulse_q, sec_pulse_d;
  logic      set_err_q, set_err_d;

`ifdef RTC_CALENDAR_ALARM_EN
  logic [W_HOUR-1:0] alarm_hour_q, alarm_hour_d;
  logic [W_MIN-1:0]  alarm_min_q, alarm_min_d;
  logic              alarm_hit_q, alarm_hit_d;
`endif

  rtc_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .clr   (clr),
    .tick  (tick)
  );

  assign set_if.set_ready = !tick;
  assign set_if.set_err   = set_err_q;
  assign accept           = set_if.set_valid && !tick;
  assign val              = set_if.set_value;
  assign cur_dim          = days_in_month(time_q.month, time_q.year);

  // next-state: tick carry chain has priority; otherwise apply an accepted write
  always_comb begin
    time_d      = time_q;
    sec_pulse_d = 1'b0;
    set_err_d   = 1'b0;
    clr         = 1'b0;
    new_dim     = cur_dim;
`ifdef RTC_CALENDAR_ALARM_EN
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_hit_d  = 1'b0;
`endif
    if (tick) begin
      sec_pulse_d = 1'b1;
      if (time_q.second == 6'd59) begin
        time_d.second = '0;
        if (time_q.minute == 6'd59) begin
          time_d.minute = '0;
          if (time_q.hour == 5'd23) begin
            time_d.hour = '0;
            time_d.week = (time_q.week == 3'd6) ? '0 : time_q.week + 1'b1;
            if (time_q.day == cur_dim) begin
              time_d.day = 5'd1;
              if (time_q.month == 4'd12) begin
                time_d.month = 4'd1;
                time_d.year  = (time_q.year == YEAR_MAX_V) ? YEAR_BASE_V : time_q.year + 1'b1;
              end else begin
                time_d.month = time_q.month + 1'b1;
              end
            end else begin
              time_d.day = time_q.day + 1'b1;
            end
          end else begin
            time_d.hour = time_q.hour + 1'b1;
          end
        end else begin
          time_d.minute = time_q.minute + 1'b1;
        end
`ifdef RTC_CALENDAR_ALARM_EN
        alarm_hit_d = (time_d.hour == alarm_hour_q) && (time_d.minute == alarm_min_q);
`endif
      end else begin
        time_d.second = time_q.second + 1'b1;
      end
    end else if (accept) begin
      case (set_if.set_field)
        FIELD_SEC: begin
          if (val <= 16'd59) begin
            time_d.second = val[W_SEC-1:0];
            clr           = 1'b1;
          end else begin
            set_err_d = 1'b1;
          end
        end
        FIELD_MIN: begin
          if (val <= 16'd59) time_d.minute = val[W_MIN-1:0];
          else               set_err_d     = 1'b1;
        end
        FIELD_HOUR: begin
          if (val <= 16'd23) time_d.hour = val[W_HOUR-1:0];
          else               set_err_d   = 1'b1;
        end
        FIELD_DAY: begin
          if (val >= 16'd1 && val <= W_VALUE'(cur_dim)) time_d.day = val[W_DAY-1:0];
          else                                          set_err_d  = 1'b1;
        end
        FIELD_MONTH: begin
          if (val >= 16'd1 && val <= 16'd12) begin
            time_d.month = val[W_MONTH-1:0];
            new_dim      = days_in_month(val[W_MONTH-1:0], time_q.year);
            if (time_q.day > new_dim) time_d.day = new_dim;
          end else begin
            set_err_d = 1'b1;
          end
        end
        FIELD_YEAR: begin
          if (val >= YEAR_BASE_V && val <= YEAR_MAX_V) begin
            time_d.year = val;
            new_dim     = days_in_month(time_q.month, val);
            if (time_q.day > new_dim) time_d.day = new_dim;
          end else begin
            set_err_d = 1'b1;
          end
        end
`ifdef RTC_CALENDAR_ALARM_EN
        FIELD_AHOUR: begin
          if (val <= 16'd23) alarm_hour_d = val[W_HOUR-1:0];
          else               set_err_d    = 1'b1;
        end
        FIELD_AMIN: begin
          if (val <= 16'd59) alarm_min_d = val[W_MIN-1:0];
          else               set_err_d   = 1'b1;
        end
`endif
        default: set_err_d = 1'b1;
      endcase
    end
  end

  // calendar state and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q      <= RESET_TIME;
      sec_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      time_q      <= time_d;
      sec_pulse_q <= sec_pulse_d;
      set_err_q   <= set_err_d;
    end
  end

`ifdef RTC_CALENDAR_ALARM_EN
  // alarm compare registers and hit pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      alarm_hit_q  <= 1'b0;
    end else begin
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hit_q  <= alarm_hit_d;
    end
  end
  assign alarm_hit = alarm_hit_q;
`else
  assign alarm_hit = 1'b0;
`endif

  assign year      = time_q.year;
  assign month     = time_q.month;
  assign day       = time_q.day;
  assign hour      = time_q.hour;
  assign minute    = time_q.minute;
  assign second    = time_q.second;
  assign week      = time_q.week;
  assign sec_pulse = sec_pulse_q;

endmodule

// File: doc/rtc_calendar.md
RTC_CALENDAR -- requirements
Module: rtc_calendar

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz; the prescaler divides by this value to form 1 Hz.
REQ-002 Parameter YEAR_BASE, default 2000, reset year and lowest legal year.
REQ-003 Parameter YEAR_MAX, default 2099, highest legal year.
REQ-004 Parameter WEEK_INIT, default 6, reset day-of-week (0=Sun..6=Sat).
REQ-005 clk  in  1  sole clock, all logic on posedge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 run  in  1  1 = time advances, 0 = prescaler and calendar frozen.
REQ-008 set_valid  in  1  field-write request.
REQ-009 set_ready  out  1  field-write accept.
REQ-010 set_field  in  3  0=sec, 1=min, 2=hour, 3=day, 4=month, 5=year, 6=alarm hour, 7=alarm min.
REQ-011 set_value  in  16  value written to set_field.
REQ-012 set_err  out  1  one-cycle pulse, write rejected.
REQ-013 year/month/day/hour/minute/second/week  out  16/4/5/5/6/6/3  current time, binary.
REQ-014 sec_pulse  out  1  one-cycle pulse on each second increment.
REQ-015 alarm_hit  out  1  one-cycle alarm pulse.

Function
REQ-016 Prescaler counts 0..CLK_HZ-1 while run=1; tick asserts for one cycle when count==CLK_HZ-1, then count returns to 0.
REQ-017 Time fields and sec_pulse update on the clock edge that follows the tick cycle, giving a latency of 1 cycle.
REQ-018 Carry chain, all in one cycle: second 59->0 carries minute; minute 59->0 carries hour; hour 23->0 carries day and week; day at last-of-month->1 carries month; month 12->1 carries year; YEAR_MAX wraps to YEAR_BASE.
REQ-019 Week increments 0..6 and wraps to 0 with every day carry.
REQ-020 Days in month: 31/30 per calendar; Feb = 29 if year%4==0 and (year%100!=0 or year%400==0), else 28.
REQ-021 set_ready = !tick; a write completes on a cycle with set_valid&&set_ready, so a tick always beats a concurrent write and the write lands the next cycle.
REQ-022 A write is legal if it is in range: sec/min 0..59, hour 0..23, day 1..days_in_month(current), month 1..12, year YEAR_BASE..YEAR_MAX; an illegal write pulses set_err the next cycle and leaves all fields unchanged.
REQ-023 A write to the second field also clears the prescaler count to 0.
REQ-024 After a month or year write, day clamps to the new days_in_month if it exceeds it, for example 31 Mar plus month=4 gives 30 Apr.
REQ-025 Week is not settable; it changes only by carry or reset.
REQ-026 When run=0, set writes still apply and sec_pulse stays 0.

Reset
REQ-027 With rst_n=0, all outputs and state take these values immediately: year=YEAR_BASE, month=1, day=1, hour=minute=second=0, week=WEEK_INIT, prescaler=0, set_err=sec_pulse=alarm_hit=0, alarm regs=0.
REQ-028 Releasing reset mid-count restarts the prescaler from 0, and any write pending at assertion is discarded.

Configuration
REQ-029 Macro RTC_CALENDAR_ALARM_EN defined: alarm hour/minute regs are writable (fields 6/7, same range rules), and alarm_hit pulses with the update that sets second to 0 when hour/minute equal the alarm regs.
REQ-030 Macro not defined: no alarm regs, alarm_hit tied 0, and writes to fields 6/7 pulse set_err.

Structure
REQ-031 Package rtc_pkg holds the set_field code localparams, the days_in_month(month, year) and is_leap(year) functions, and the field widths.
REQ-032 The prescaler is sub-module rtc_prescaler (ports clk, rst_n, en, clr, tick); calendar logic stays in rtc_calendar.
REQ-033 The bench overrides CLK_HZ to a small value (e.g. 4).

Verification
REQ-034 Set 2023-12-31 23:59:59, one tick -> 2024-01-01 00:00:00, week +1, sec_pulse once.
REQ-035 Set year 2024, Feb 28 23:59:59, tick -> Feb 29; year 2100 (YEAR_MAX=2199) same stimulus -> Mar 1.
REQ-036 Write minute=60 -> set_err one cycle, minute unchanged; day=31 at Mar, then month=4 -> day=30.
REQ-037 set_valid asserted on the tick cycle -> set_ready=0, tick applied, write applied the next cycle.
REQ-038 Drop rst_n mid-count, then release -> outputs at the REQ-027 values immediately, first tick CLK_HZ cycles after release.
REQ-039 With ALARM_EN, alarm 07:30, time 07:29:59, tick -> alarm_hit one cycle; without ALARM_EN, write field 6 -> set_err.
